// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with ack timeout
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ready,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic             dbg_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             timeout_flag
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_grant;   // 1: debug port was granted most recently
    logic              lat_we;
    logic [WIDTH-1:0]  lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic [CW-1:0]     wait_cnt;
    logic              in_acc;
    logic              grant;

    assign in_acc = (state == CPU_ACC) || (state == DBG_ACC);
    assign grant  = (state == IDLE) && (next_state != IDLE);

    // Memory strobes are decoded from the state register so they drop the
    // moment reset forces IDLE; latched fields are gated to zero outside ACC.
    assign mem_en    = in_acc;
    assign mem_we    = in_acc && lat_we;
    assign mem_addr  = in_acc ? lat_addr  : '0;
    assign mem_wdata = in_acc ? lat_wdata : '0;

    // last_grant always names the port of the access being completed in RESP.
    assign cpu_ready = (state == RESP) && !last_grant;
    assign dbg_ready = (state == RESP) && last_grant;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: round-robin on ties, ack beats timeout, RESP lasts one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    next_state = last_grant ? CPU_ACC : DBG_ACC;
                end else if (cpu_req) begin
                    next_state = CPU_ACC;
                end else if (dbg_req) begin
                    next_state = DBG_ACC;
                end
            end
            CPU_ACC, DBG_ACC: begin
                if (mem_ack || (wait_cnt == LAST_WAIT)) begin
                    next_state = RESP;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant latching, wait counting, read-data capture and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant   <= 1'b1;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            wait_cnt     <= '0;
            cpu_rdata    <= '0;
            dbg_rdata    <= '0;
            timeout_flag <= 1'b0;
        end else if (grant) begin
            wait_cnt <= '0;
            if (next_state == DBG_ACC) begin
                last_grant <= 1'b1;
                lat_we     <= dbg_we;
                lat_addr   <= dbg_addr;
                lat_wdata  <= dbg_wdata;
            end else begin
                last_grant <= 1'b0;
                lat_we     <= cpu_we;
                lat_addr   <= cpu_addr;
                lat_wdata  <= cpu_wdata;
            end
        end else if (in_acc) begin
            if (mem_ack) begin
                if (!lat_we) begin
                    if (last_grant) begin
                        dbg_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end else if (wait_cnt == LAST_WAIT) begin
                // Forced completion: a timed-out read returns zero
                timeout_flag <= 1'b1;
                if (!lat_we) begin
                    if (last_grant) begin
                        dbg_rdata <= '0;
                    end else begin
                        cpu_rdata <= '0;
                    end
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
